// File: rtl/pixel_frame_receiver_pkg.sv
// Shared configuration for the pixel readout path: default geometry,
// the frame receiver state encoding and derived constants.
package PixelSensorConfig;

  localparam int PIXEL_ARRAY_WIDTH_DEF  = 24;
  localparam int PIXEL_ARRAY_HEIGHT_DEF = 12;
  localparam int PIXEL_BITS_DEF         = 8;
  localparam int OUTPUT_BUS_WIDTH_DEF   = 8;

  localparam int BEATS_PER_ROW = PIXEL_ARRAY_WIDTH_DEF / OUTPUT_BUS_WIDTH_DEF;
  localparam int CHECKSUM_BITS = 16;

  typedef enum logic [1:0] {
    RX_IDLE    = 2'd0,
    RX_RECEIVE = 2'd1,
    RX_HOLD    = 2'd2
  } rx_state_e;

endpackage

// File: rtl/pixel_frame_receiver_buffer.sv
// Frame storage for pixel_frame_receiver: one beat-wide write port addressed
// by (row, beat) and one registered single-pixel read port (0 when out of range).
module pixel_frame_buffer #(
  parameter int H      = 12,
  parameter int W      = 24,
  parameter int PB     = 8,
  parameter int OBW    = 8,
  parameter int ROW_W  = $clog2(H),
  parameter int COL_W  = $clog2(W),
  parameter int BEAT_W = ((W / OBW) > 1) ? $clog2(W / OBW) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [ROW_W-1:0]  wr_row_i,
  input  logic [BEAT_W-1:0] wr_beat_i,
  input  logic [OBW*PB-1:0] wr_data_i,
  input  logic [ROW_W-1:0]  rd_row_i,
  input  logic [COL_W-1:0]  rd_col_i,
  output logic [PB-1:0]     rd_data_o
);

  logic [PB-1:0] mem [H][W];
  logic [PB-1:0] rd_data_q;

  // Storage is never reset; only the read register is.
  always_ff @(posedge clk) begin
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (wr_en_i && (wr_row_i == ROW_W'(r)) && (wr_beat_i == BEAT_W'(c / OBW))) begin
          mem[r][c] <= wr_data_i[(c % OBW)*PB +: PB];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if ((int'(rd_row_i) < H) && (int'(rd_col_i) < W)) begin
      rd_data_q <= mem[rd_row_i][rd_col_i];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/pixel_frame_receiver.sv
// Reassembles pixel-bus beats into a held frame with random-access readout.
// Optional running checksum enabled by defining PIXEL_FRAME_CHECKSUM_EN.
module pixel_frame_receiver
  import PixelSensorConfig::*;
#(
  parameter int PIXEL_ARRAY_WIDTH  = PIXEL_ARRAY_WIDTH_DEF,
  parameter int PIXEL_ARRAY_HEIGHT = PIXEL_ARRAY_HEIGHT_DEF,
  parameter int PIXEL_BITS         = PIXEL_BITS_DEF,
  parameter int OUTPUT_BUS_WIDTH   = OUTPUT_BUS_WIDTH_DEF
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start_of_frame,
  input  logic                                   data_valid,
  input  logic [OUTPUT_BUS_WIDTH*PIXEL_BITS-1:0] data_in,
  input  logic                                   frame_ack,
  input  logic [$clog2(PIXEL_ARRAY_HEIGHT)-1:0]  rd_row,
  input  logic [$clog2(PIXEL_ARRAY_WIDTH)-1:0]   rd_col,
  output logic [PIXEL_BITS-1:0]                  rd_data,
  output logic                                   frame_ready,
  output logic                                   frame_error,
  output logic [7:0]                             frame_count,
  output logic [CHECKSUM_BITS-1:0]               frame_checksum
);

  localparam int BPR    = PIXEL_ARRAY_WIDTH / OUTPUT_BUS_WIDTH;
  localparam int ROW_W  = $clog2(PIXEL_ARRAY_HEIGHT);
  localparam int COL_W  = $clog2(PIXEL_ARRAY_WIDTH);
  localparam int BEAT_W = (BPR > 1) ? $clog2(BPR) : 1;
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(PIXEL_ARRAY_HEIGHT - 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BPR - 1);

  rx_state_e         state_q;
  logic [ROW_W-1:0]  row_q, row_d, wr_row;
  logic [BEAT_W-1:0] beat_q, beat_d, wr_beat;
  logic              frame_ready_q, frame_error_q;
  logic [7:0]        frame_count_q;
  logic              we, sof_acc, err_set, last_beat;

  // Decide whether this cycle's beat is written and whether it restarts a frame.
  always_comb begin
    we      = 1'b0;
    sof_acc = 1'b0;
    err_set = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (data_valid && start_of_frame) begin
          we      = 1'b1;
          sof_acc = 1'b1;
        end
      end
      RX_RECEIVE: begin
        if (data_valid) begin
          we = 1'b1;
          if (start_of_frame) begin
            sof_acc = 1'b1;
            err_set = 1'b1;
          end
        end
      end
      RX_HOLD: begin
        if (frame_ack) begin
          if (data_valid && start_of_frame) begin
            we      = 1'b1;
            sof_acc = 1'b1;
          end
        end else if (data_valid) begin
          err_set = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign wr_row    = sof_acc ? '0 : row_q;
  assign wr_beat   = sof_acc ? '0 : beat_q;
  assign last_beat = we && (wr_row == LAST_ROW) && (wr_beat == LAST_BEAT);

  always_comb begin
    beat_d = wr_beat + BEAT_W'(1);
    row_d  = wr_row;
    if (wr_beat == LAST_BEAT) begin
      beat_d = '0;
      row_d  = (wr_row == LAST_ROW) ? '0 : wr_row + ROW_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RX_IDLE;
      row_q         <= '0;
      beat_q        <= '0;
      frame_ready_q <= 1'b0;
      frame_error_q <= 1'b0;
      frame_count_q <= '0;
    end else begin
      if ((state_q == RX_HOLD) && frame_ack) begin
        frame_ready_q <= 1'b0;
        frame_error_q <= 1'b0;
        state_q       <= RX_IDLE;
      end
      if (err_set) frame_error_q <= 1'b1;
      if (we) begin
        row_q  <= row_d;
        beat_q <= beat_d;
        if (last_beat) begin
          state_q       <= RX_HOLD;
          frame_ready_q <= 1'b1;
          frame_count_q <= frame_count_q + 8'd1;
        end else begin
          state_q <= RX_RECEIVE;
        end
      end
    end
  end

  assign frame_ready = frame_ready_q;
  assign frame_error = frame_error_q;
  assign frame_count = frame_count_q;

`ifdef PIXEL_FRAME_CHECKSUM_EN
  function automatic logic [CHECKSUM_BITS-1:0] beat_sum(
    input logic [OUTPUT_BUS_WIDTH*PIXEL_BITS-1:0] d
  );
    logic [CHECKSUM_BITS-1:0] s;
    s = '0;
    for (int j = 0; j < OUTPUT_BUS_WIDTH; j++) begin
      s = s + CHECKSUM_BITS'(d[j*PIXEL_BITS +: PIXEL_BITS]);
    end
    return s;
  endfunction

  logic [CHECKSUM_BITS-1:0] csum_run_q, csum_d, frame_checksum_q;

  // A restarting beat seeds the sum instead of adding to the old one.
  assign csum_d = (sof_acc ? '0 : csum_run_q) + beat_sum(data_in);

  always_ff @(posedge clk) begin
    if (reset) begin
      csum_run_q       <= '0;
      frame_checksum_q <= '0;
    end else if (we) begin
      csum_run_q <= csum_d;
      if (last_beat) frame_checksum_q <= csum_d;
    end
  end

  assign frame_checksum = frame_checksum_q;
`else
  assign frame_checksum = '0;
`endif

  pixel_frame_buffer #(
    .H     (PIXEL_ARRAY_HEIGHT),
    .W     (PIXEL_ARRAY_WIDTH),
    .PB    (PIXEL_BITS),
    .OBW   (OUTPUT_BUS_WIDTH),
    .ROW_W (ROW_W),
    .COL_W (COL_W),
    .BEAT_W(BEAT_W)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .wr_en_i  (we),
    .wr_row_i (wr_row),
    .wr_beat_i(wr_beat),
    .wr_data_i(data_in),
    .rd_row_i (rd_row),
    .rd_col_i (rd_col),
    .rd_data_o(rd_data)
  );

endmodule

// File: tb/tb_pixel_frame_receiver.sv
// Scoreboard bench for pixel_frame_receiver (default 24x12 geometry).
module tb_pixel_frame_receiver;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_of_frame;
  logic        data_valid;
  logic [63:0] data_in;
  logic        frame_ack;
  logic [3:0]  rd_row;
  logic [4:0]  rd_col;
  logic [7:0]  rd_data;
  logic        frame_ready;
  logic        frame_error;
  logic [7:0]  frame_count;
  logic [15:0] frame_checksum;

  int n_checks = 0;
  int n_errors = 0;
  int exp_mem [12][24];
  int exp_q [$];
  int exp_count = 0;

  always #5 clk = ~clk;

  pixel_frame_receiver dut (
    .clk           (clk),
    .reset         (reset),
    .start_of_frame(start_of_frame),
    .data_valid    (data_valid),
    .data_in       (data_in),
    .frame_ack     (frame_ack),
    .rd_row        (rd_row),
    .rd_col        (rd_col),
    .rd_data       (rd_data),
    .frame_ready   (frame_ready),
    .frame_error   (frame_error),
    .frame_count   (frame_count),
    .frame_checksum(frame_checksum)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pix(input int k, input int j, input int off, input bit ff);
    return ff ? 255 : ((k*8 + j + off) % 256);
  endfunction

  function automatic logic [63:0] beat_data(input int k, input int off, input bit ff);
    logic [63:0] d;
    for (int j = 0; j < 8; j++) d[j*8 +: 8] = 8'(pix(k, j, off, ff));
    return d;
  endfunction

  task automatic model_write(input int k, input int off, input bit ff);
    for (int j = 0; j < 8; j++) exp_mem[k/3][(k%3)*8 + j] = pix(k, j, off, ff);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input bit sof, input bit ack, input logic [63:0] d);
    data_in = d; data_valid = 1'b1; start_of_frame = sof; frame_ack = ack;
    tick();
    data_valid = 1'b0; start_of_frame = 1'b0; frame_ack = 1'b0;
  endtask

  task automatic rd_chk(input int r, input int c);
    int e;
    exp_q.push_back((r < 12 && c < 24) ? exp_mem[r][c] : 0);
    rd_row = 4'(r);
    rd_col = 5'(c);
    tick();
    e = exp_q.pop_front();
    chk($sformatf("rd(%0d,%0d)", r, c), rd_data, e);
  endtask

  task automatic send_frame(input int off, input bit ff, input bit with_ack,
                            input bit gap, input bit exp_err);
    int sum = 0;
    for (int k = 0; k < 36; k++) begin
      drive_beat(k == 0, (k == 0) && with_ack, beat_data(k, off, ff));
      model_write(k, off, ff);
      for (int j = 0; j < 8; j++) sum += pix(k, j, off, ff);
      if (k == 0) begin
        chk("sof_rdy", frame_ready, 0);
        chk("sof_err", frame_error, exp_err);
      end
      if (k == 34) chk("rdy_early", frame_ready, 0);
      if (gap) begin
        frame_ack = (k == 5);
        tick();
        frame_ack = 1'b0;
      end
    end
    exp_count = (exp_count + 1) % 256;
    chk("rdy", frame_ready, 1);
    chk("count", frame_count, exp_count);
`ifdef PIXEL_FRAME_CHECKSUM_EN
    chk("csum", frame_checksum, sum % 65536);
`else
    chk("csum", frame_checksum, 0);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_rd"}, rd_data, 0);
    chk({tag, "_rdy"}, frame_ready, 0);
    chk({tag, "_err"}, frame_error, 0);
    chk({tag, "_cnt"}, frame_count, 0);
    chk({tag, "_csum"}, frame_checksum, 0);
  endtask

  initial begin
    reset = 1'b1; start_of_frame = 1'b0; data_valid = 1'b0; data_in = '0;
    frame_ack = 1'b0; rd_row = '0; rd_col = '0;
    for (int r = 0; r < 12; r++) for (int c = 0; c < 24; c++) exp_mem[r][c] = 0;
    tick(); tick();
    check_all_zero("rst");
    reset = 1'b0;

    // Full back-to-back frame
    send_frame(0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("known_11_23", exp_mem[11][23], 31);
    rd_chk(11, 23);
    rd_chk(2, 5);
    rd_chk(12, 0);
    rd_chk(0, 24);
    rd_chk(15, 31);
    for (int i = 0; i < 6; i++) rd_chk($urandom_range(0, 11), $urandom_range(0, 23));

    // Overrun in HOLD, then ack together with SOF into a gapped frame
    drive_beat(1'b0, 1'b0, {8{8'hAA}});
    chk("ovr_err", frame_error, 1);
    chk("ovr_rdy", frame_ready, 1);
    rd_chk(0, 0);
    rd_chk(5, 9);
    send_frame(100, 1'b0, 1'b1, 1'b1, 1'b0);
    rd_chk(0, 0);
    rd_chk(11, 23);
    for (int i = 0; i < 6; i++) rd_chk($urandom_range(0, 11), $urandom_range(0, 23));

    // Plain ack, stray beat in IDLE, then restart mid-frame
    frame_ack = 1'b1; tick(); frame_ack = 1'b0;
    chk("ack_rdy", frame_ready, 0);
    chk("ack_err", frame_error, 0);
    drive_beat(1'b0, 1'b0, {8{8'h55}});
    chk("idle_err", frame_error, 0);
    rd_chk(0, 1);
    for (int k = 0; k < 10; k++) begin
      drive_beat(k == 0, 1'b0, beat_data(k, 50, 1'b0));
      model_write(k, 50, 1'b0);
    end
    chk("part_rdy", frame_ready, 0);
    send_frame(0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("restart_err", frame_error, 1);
    rd_chk(3, 7);
    rd_chk(1, 20);

    // Reset mid-frame
    frame_ack = 1'b1; tick(); frame_ack = 1'b0;
    for (int k = 0; k < 20; k++) begin
      drive_beat(k == 0, 1'b0, beat_data(k, 200, 1'b0));
      model_write(k, 200, 1'b0);
    end
    reset = 1'b1; tick(); reset = 1'b0;
    check_all_zero("midrst");
    exp_count = 0;
    send_frame(7, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("midrst_err", frame_error, 0);
    rd_chk(6, 6);
    rd_chk(11, 0);

    // All-0xFF frame
    send_frame(0, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef PIXEL_FRAME_CHECKSUM_EN
    chk("csum_ff", frame_checksum, 7904);
`else
    chk("csum_ff", frame_checksum, 0);
`endif
    rd_chk(4, 13);

    // Run frames until frame_count wraps past 255
    do begin
      send_frame(exp_count, 1'b0, 1'b1, 1'b0, 1'b0);
    end while (exp_count != 0);
    chk("wrap", frame_count, 0);
    rd_chk(9, 17);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
